// File: rtl/mips_pipe_pkg.sv
// Shared fetch-stage constants and state encoding for the MIPS pipeline slice.
package mips_pipe_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_INC_DEF   = 32'd4;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD_PEND = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_latch.sv
// Holds one branch target resolved while fetch is stalled, until the next advance consumes it.
module fetch_redirect_latch
  import mips_pipe_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_set,
  input  logic            i_clr,
  input  logic [PC_W-1:0] i_target,
  output logic            o_valid,
  output logic [PC_W-1:0] o_target
);

  logic            r_valid;
  logic [PC_W-1:0] r_target;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_target <= '0;
    end else if (i_clr) begin
      r_valid  <= 1'b0;
    end else if (i_set) begin
      r_valid  <= 1'b1;
      r_target <= i_target;
    end
  end

  assign o_valid  = r_valid;
  assign o_target = r_target;

endmodule

// File: rtl/pc_fetch_stage.sv
// PC/nPC sequencer with MIPS delayed branching, stall hold and a pending-redirect latch.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
//
//   state     | meaning
//   BOOT      | first cycle after reset; PC/NPC held, IF_VALID rises on exit
//   RUN       | normal fetch; advances on LE, accepts one redirect per delay window
//   HOLD_PEND | stalled with a captured redirect waiting for the next advance
module pc_fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] PC_INC   = PC_INC_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            LE,
  input  logic            BR_TAKEN,
  input  logic [PC_W-1:0] BR_TARGET,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] NPC,
  output logic            IF_VALID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     FETCH_CNT,
  output logic [31:0]     STALL_CNT,
  output logic [15:0]     DROP_CNT
`endif
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_npc;
  logic            r_valid;
  logic            r_in_slot;

  logic [PC_W-1:0] w_target;
  logic            w_accept;
  logic            w_capture;
  logic            w_pend_clr;
  logic            w_pend_valid;
  logic [PC_W-1:0] w_pend_target;

  assign w_target   = BR_TARGET & ~32'h3;
  // r_in_slot blocks a second redirect until the delay-slot advance has happened
  assign w_accept   = (r_state == RUN) && LE && BR_TAKEN && !r_in_slot;
  assign w_capture  = (r_state == RUN) && !LE && BR_TAKEN && !r_in_slot;
  assign w_pend_clr = (r_state == HOLD_PEND) && LE;

  fetch_redirect_latch u_latch (
    .i_clk    (Clk),
    .i_rst_n  (Reset),
    .i_set    (w_capture),
    .i_clr    (w_pend_clr),
    .i_target (w_target),
    .o_valid  (w_pend_valid),
    .o_target (w_pend_target)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_npc     <= RESET_PC + PC_INC;
      r_valid   <= 1'b0;
      r_in_slot <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_valid <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          if (LE) begin
            r_pc      <= r_npc;
            r_npc     <= w_accept ? w_target : r_npc + PC_INC;
            r_in_slot <= w_accept;
          end else if (w_capture) begin
            r_state <= HOLD_PEND;
          end
        end
        HOLD_PEND: begin
          if (LE) begin
            r_pc      <= r_npc;
            r_npc     <= w_pend_valid ? w_pend_target : r_npc + PC_INC;
            r_in_slot <= 1'b1;
            r_state   <= RUN;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign PC       = r_pc;
  assign NPC      = r_npc;
  assign IF_VALID = r_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [15:0] r_drop_cnt;
  logic        w_active;

  assign w_active = (r_state != BOOT);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_active && LE)  r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_active && !LE) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (BR_TAKEN && !w_accept && !w_capture) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign FETCH_CNT = r_fetch_cnt;
  assign STALL_CNT = r_stall_cnt;
  assign DROP_CNT  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench: two fetch stages (reset PC 0 and 0xFFFF_FFF8) share random stimulus.
module tb_pc_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        vld;
  } exp_t;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        le = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc0, npc0, pc1, npc1;
  logic        vld0, vld1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fc0, sc0, fc1, sc1;
  logic [15:0] dc0, dc1;
`endif

  always #5 clk = ~clk;

  pc_fetch_stage #(.RESET_PC(RPC0), .PC_INC(32'd4)) dut0 (
    .Clk(clk), .Reset(rst_n), .LE(le), .BR_TAKEN(br), .BR_TARGET(tgt),
    .PC(pc0), .NPC(npc0), .IF_VALID(vld0)
`ifdef FETCH_PERF_CNT_EN
    , .FETCH_CNT(fc0), .STALL_CNT(sc0), .DROP_CNT(dc0)
`endif
  );

  pc_fetch_stage #(.RESET_PC(RPC1), .PC_INC(32'd4)) dut1 (
    .Clk(clk), .Reset(rst_n), .LE(le), .BR_TAKEN(br), .BR_TARGET(tgt),
    .PC(pc1), .NPC(npc1), .IF_VALID(vld1)
`ifdef FETCH_PERF_CNT_EN
    , .FETCH_CNT(fc1), .STALL_CNT(sc1), .DROP_CNT(dc1)
`endif
  );

  // Reference: current address, the address after it, and any redirect owed to the stream.
  logic [31:0] m_pc[2], m_npc[2], m_pend[2];
  logic        m_vld[2], m_boot[2], m_pend_has[2], m_slot[2];
  exp_t        exp_q0[$], exp_q1[$];
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic [31:0] rpc(input int d);
    return (d == 0) ? RPC0 : RPC1;
  endfunction

  function automatic void mstep(input int d, input logic r, input logic l,
                                input logic b, input logic [31:0] t);
    logic [31:0] tt;
    logic [31:0] follow;
    logic        took;
    tt = {t[31:2], 2'b00};
    if (!r) begin
      m_pc[d] = rpc(d);  m_npc[d] = rpc(d) + 32'd4;
      m_vld[d] = 1'b0;   m_boot[d] = 1'b1;
      m_pend_has[d] = 1'b0; m_slot[d] = 1'b0;
    end else if (m_boot[d]) begin
      m_boot[d] = 1'b0;
      m_vld[d]  = 1'b1;
    end else if (!l) begin
      if (b && !m_pend_has[d] && !m_slot[d]) begin
        m_pend_has[d] = 1'b1;
        m_pend[d]     = tt;
      end
    end else begin
      took = 1'b1;
      if (m_pend_has[d])           follow = m_pend[d];
      else if (b && !m_slot[d])    follow = tt;
      else begin follow = m_npc[d] + 32'd4; took = 1'b0; end
      m_pc[d]  = m_npc[d];
      m_npc[d] = follow;
      m_pend_has[d] = 1'b0;
      m_slot[d] = took;
    end
  endfunction

  task automatic step(input logic r, input logic l, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst_n = r; le = l; br = b; tgt = t;
    @(posedge clk);
    mstep(0, r, l, b, t);
    mstep(1, r, l, b, t);
    exp_q0.push_back('{pc: m_pc[0], npc: m_npc[0], vld: m_vld[0]});
    exp_q1.push_back('{pc: m_pc[1], npc: m_npc[1], vld: m_vld[1]});
  endtask

  task automatic chk(input int d, input exp_t e, input logic [31:0] apc,
                     input logic [31:0] anpc, input logic avld);
    n_vec++;
    if (apc !== e.pc || anpc !== e.npc || avld !== e.vld) begin
      n_miss++;
      $display("FAIL dut%0d pc/npc/vld: got %h/%h/%b want %h/%h/%b",
               d, apc, anpc, avld, e.pc, e.npc, e.vld);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q0.size() > 0) chk(0, exp_q0.pop_front(), pc0, npc0, vld0);
    if (exp_q1.size() > 0) chk(1, exp_q1.pop_front(), pc1, npc1, vld1);
  end

  initial begin
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    // taken branch from PC=8: delay slot 12, then 0x40
    step(1, 1, 1, 32'h40);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    // redirect during a stall, second one during the same stall dropped
    step(1, 0, 1, 32'h80); step(1, 0, 1, 32'h90); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    // branch in the delay slot is ignored
    step(1, 1, 1, 32'h100); step(1, 1, 1, 32'h200); step(1, 1, 0, 0);
    // reset while a redirect is pending
    step(1, 0, 1, 32'h300); step(0, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), $urandom);
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d/%0d entries left want 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
